// File: rtl/trng_collect_pkg.sv
// Shared types and sizing constants for the entropy collector and its health test.
package trng_collect_pkg;

  // Collector states: FILL packs bits, FULL holds a word, FAULT latches a health failure.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } coll_state_e;

  // Default output word width and repetition-count limit.
  localparam int WIDTH_DEF     = 32;
  localparam int REP_LIMIT_DEF = 16;

  // Run counter width; 8 bits covers every legal limit up to 255.
  localparam int RUN_W = 8;

  // Bit-position counter width for a given word width (counts 0..w-1).
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/entropy_collector_if.sv
// Word handshake between the entropy collector (master) and the TRNG register side (slave).
interface entropy_collector_if #(
  parameter int WIDTH = trng_collect_pkg::WIDTH_DEF
);
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             ready;

  modport master (output data_out, output valid, input ready);
  modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/rep_count_test.sv
// Online repetition-count health test for a serial raw entropy stream.
// fail is a combinational single-cycle pulse, high on the sampling cycle whose
// bit makes the run of identical bits reach 'limit'; the caller registers it.
module rep_count_test
  import trng_collect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             enb,
  input  logic             bit_in,
  input  logic [RUN_W-1:0] limit,
  output logic             fail
);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             first_q, first_d;

  // Next run length, last bit and first-bit flag; clr re-arms the test.
  always_comb begin
    run_d   = run_q;
    last_d  = last_q;
    first_d = first_q;
    fail    = 1'b0;
    if (clr) begin
      run_d   = '0;
      last_d  = 1'b0;
      first_d = 1'b1;
    end else if (enb) begin
      if (first_q) begin
        run_d = RUN_W'(1);
      end else if (bit_in == last_q) begin
        if (run_q == {RUN_W{1'b1}}) begin
          run_d = run_q;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        run_d = RUN_W'(1);
      end
      last_d  = bit_in;
      first_d = 1'b0;
      fail    = (run_d >= limit);
    end else begin
      run_d = run_q;
    end
  end

  // Run-state registers; the first-bit flag comes out of reset armed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      run_q   <= run_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Entropy collector: samples the raw ring-oscillator bit stream, packs it into
// WIDTH-bit words offered over a valid/ready handshake, and latches a sticky
// alarm when the repetition-count health test fails.
// Optional macro TRNG_VN_DEBIAS_EN inserts a Von Neumann corrector between
// sampling and packing (01->0, 10->1, 00/11 dropped); the health test always
// sees the raw bits.
module entropy_collector
  import trng_collect_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                bit_in,
  input  logic                clr,
  entropy_collector_if.master bus,
  output logic                alarm
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0] LIMIT    = RUN_W'(REP_LIMIT);

  coll_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             alarm_q, alarm_d;

  logic             samp_en;
  logic             rep_fail;
  logic             pack_en;
  logic             pack_bit;

  // The health test keeps running in FILL and FULL but is frozen once faulted.
  assign samp_en = enb & (state_q != FAULT);

  rep_count_test u_rep (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .enb    (samp_en),
    .bit_in (bit_in),
    .limit  (LIMIT),
    .fail   (rep_fail)
  );

`ifdef TRNG_VN_DEBIAS_EN
  logic phase_q, phase_d;
  logic pair_q, pair_d;

  // Corrector output: emit the first bit of a differing pair on its second sample.
  always_comb begin
    pack_en  = 1'b0;
    pack_bit = 1'b0;
    if (enb && phase_q) begin
      pack_en  = pair_q ^ bit_in;
      pack_bit = pair_q;
    end else begin
      pack_en  = 1'b0;
      pack_bit = 1'b0;
    end
  end

  // Pair phase advances only while filling; outside FILL it is held at zero so
  // every entry to FILL starts on a fresh pair.
  always_comb begin
    phase_d = phase_q;
    pair_d  = pair_q;
    if (clr) begin
      phase_d = 1'b0;
    end else if ((state_q == FILL) && !rep_fail && enb) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        pair_d = bit_in;
      end else begin
        pair_d = pair_q;
      end
    end else if (state_q != FILL) begin
      phase_d = 1'b0;
    end else begin
      phase_d = phase_q;
    end
  end

  // Corrector pair registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      pair_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pair_q  <= pair_d;
    end
  end
`else
  // Without the corrector every sampled raw bit is packed directly.
  always_comb begin
    pack_en  = enb;
    pack_bit = bit_in;
  end
`endif

  // Collector next state: clr beats an alarm trigger, which beats packing and the handshake.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    alarm_d = alarm_q;
    if (clr) begin
      state_d = FILL;
      shreg_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (rep_fail) begin
            alarm_d = 1'b1;
            valid_d = 1'b0;
            shreg_d = '0;
            cnt_d   = '0;
            state_d = FAULT;
          end else if (pack_en) begin
            if (cnt_q == LAST_CNT) begin
              data_d  = {shreg_q[WIDTH-2:0], pack_bit};
              valid_d = 1'b1;
              shreg_d = '0;
              cnt_d   = '0;
              state_d = FULL;
            end else begin
              shreg_d = {shreg_q[WIDTH-2:0], pack_bit};
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = FILL;
          end
        end
        FULL: begin
          if (rep_fail) begin
            alarm_d = 1'b1;
            valid_d = 1'b0;
            state_d = FAULT;
          end else if (bus.ready) begin
            valid_d = 1'b0;
            state_d = FILL;
          end else begin
            state_d = FULL;
          end
        end
        FAULT: begin
          alarm_d = 1'b1;
          valid_d = 1'b0;
        end
        default: begin
          state_d = FILL;
          shreg_d = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Collector state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign alarm        = alarm_q;

endmodule

// File: tb/tb_entropy_collector.sv
// Directed self-checking bench for entropy_collector (WIDTH=32, REP_LIMIT=16).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_entropy_collector;

  logic clk = 1'b0;
  logic rst;
  logic enb;
  logic bit_in;
  logic clr;
  logic ready;
  logic alarm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  entropy_collector_if #(.WIDTH(32)) bus_if ();
  assign bus_if.ready = ready;

  entropy_collector #(.WIDTH(32), .REP_LIMIT(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .enb    (enb),
    .bit_in (bit_in),
    .clr    (clr),
    .bus    (bus_if.master),
    .alarm  (alarm)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sample(input logic e, input logic b);
    enb    = e;
    bit_in = b;
    @(posedge clk);
    #1;
  endtask

  // Feeds w MSB first; valid must rise exactly after the 32nd sample.
  task automatic collect_word(input string tag, input logic [31:0] w);
    for (int i = 31; i >= 1; i--) sample(1'b1, w[i]);
    check_eq({tag, "_v31"}, {31'd0, bus_if.valid}, 32'd0);
    sample(1'b1, w[0]);
    check_eq({tag, "_valid"}, {31'd0, bus_if.valid}, 32'd1);
    check_eq({tag, "_data"}, bus_if.data_out, w);
    check_eq({tag, "_alarm"}, {31'd0, alarm}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    ready = 1'b1;
    sample(1'b0, 1'b0);
    ready = 1'b0;
    check_eq({tag, "_hs_valid"}, {31'd0, bus_if.valid}, 32'd0);
  endtask

  task automatic clear();
    clr = 1'b1;
    sample(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  // 15 equal bits are tolerated, the 16th trips the alarm, which is sticky until clr.
  task automatic alarm_run();
    clear();
    for (int i = 0; i < 15; i++) sample(1'b1, 1'b1);
    check_eq("rep15_alarm", {31'd0, alarm}, 32'd0);
    sample(1'b1, 1'b1);
    check_eq("rep16_alarm", {31'd0, alarm}, 32'd1);
    check_eq("rep16_valid", {31'd0, bus_if.valid}, 32'd0);
    for (int i = 0; i < 5; i++) sample(1'b1, 1'b0);
    check_eq("fault_alarm_held", {31'd0, alarm}, 32'd1);
    check_eq("fault_valid_held", {31'd0, bus_if.valid}, 32'd0);
    clear();
    check_eq("clr_alarm", {31'd0, alarm}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    enb    = 1'b0;
    bit_in = 1'b0;
    clr    = 1'b0;
    ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", bus_if.data_out, 32'd0);
    check_eq("rst_valid", {31'd0, bus_if.valid}, 32'd0);
    check_eq("rst_alarm", {31'd0, alarm}, 32'd0);
    rst = 1'b0;
    sample(1'b0, 1'b0);

`ifdef TRNG_VN_DEBIAS_EN
    // Raw pairs 01,10,00,11 yield 0,1 per 8 raw bits -> 0x55555555 after 128 samples.
    for (int r = 0; r < 16; r++) begin
      sample(1'b1, 1'b0); sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b1, 1'b0);
      sample(1'b1, 1'b0); sample(1'b1, 1'b0); sample(1'b1, 1'b1);
      if (r == 15) check_eq("vn_v127", {31'd0, bus_if.valid}, 32'd0);
      sample(1'b1, 1'b1);
    end
    check_eq("vn_valid", {31'd0, bus_if.valid}, 32'd1);
    check_eq("vn_data", bus_if.data_out, 32'h5555_5555);
    handshake("vn");
    alarm_run();
`else
    // Alternating bits from reset.
    collect_word("alt", 32'hAAAA_AAAA);

    // Stall with ready low: word and valid hold while bits keep arriving.
    for (int i = 0; i < 10; i++) begin
      sample(1'b1, i[0]);
      check_eq("stall_valid", {31'd0, bus_if.valid}, 32'd1);
      check_eq("stall_data", bus_if.data_out, 32'hAAAA_AAAA);
    end
    handshake("stall");
    check_eq("post_hs_data", bus_if.data_out, 32'hAAAA_AAAA);
    collect_word("fresh", 32'h1234_5678);
    handshake("fresh");

    // Health test, then the bit counter must restart from zero after clr.
    alarm_run();
    collect_word("after_clr", 32'hAAAA_AAAA);

    // clr together with valid&ready drops the word; the bit sampled with clr is ignored.
    clr   = 1'b1;
    ready = 1'b1;
    sample(1'b1, 1'b1);
    clr   = 1'b0;
    ready = 1'b0;
    check_eq("clr_hs_valid", {31'd0, bus_if.valid}, 32'd0);
    check_eq("clr_hs_alarm", {31'd0, alarm}, 32'd0);
    collect_word("clr_bit_ign", 32'hC3A5_5A3C);
    handshake("clr_bit_ign");

    // enb toggling: disabled cycles carry the opposite bit, which must be ignored.
    for (int i = 0; i < 64; i++) begin
      sample(~i[0], i[0] ? i[1] : ~i[1]);
      if (i == 61) check_eq("tog_v61", {31'd0, bus_if.valid}, 32'd0);
      if (i == 62) begin
        check_eq("tog_valid", {31'd0, bus_if.valid}, 32'd1);
        check_eq("tog_data", bus_if.data_out, 32'hAAAA_AAAA);
      end
    end
    handshake("tog");

    // Alarm trigger on the same cycle as the 32nd bit: FAULT wins, valid stays 0.
    clear();
    for (int i = 0; i < 16; i++) sample(1'b1, ~i[0]);
    for (int i = 0; i < 15; i++) sample(1'b1, 1'b1);
    check_eq("edge31_alarm", {31'd0, alarm}, 32'd0);
    check_eq("edge31_valid", {31'd0, bus_if.valid}, 32'd0);
    sample(1'b1, 1'b1);
    check_eq("edge32_alarm", {31'd0, alarm}, 32'd1);
    check_eq("edge32_valid", {31'd0, bus_if.valid}, 32'd0);
    clear();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entropy_collector.md
Name: entropy_collector

Overview:
- Consumer end of the ring-oscillator entropy bit stream.
- Samples the serial raw entropy bit on each enabled cycle and packs bits into WIDTH-bit words.
- Runs an online repetition-count health test on the raw bits.
- Presents each completed word to the TRNG register/bus side over a valid/ready handshake.

Parameters:
- WIDTH, 32, output word width in bits (≥2)
- REP_LIMIT, 16, run length of identical consecutive raw bits that raises alarm (2..255)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- enb  input  1  sample strobe; bit_in is consumed only when high
- bit_in  input  1  serial raw entropy bit from the entropy generator
- clr  input  1  synchronous clear: discards partial word, clears alarm, returns to FILL
- data_out  output  WIDTH  collected entropy word, stable while valid=1
- valid  output  1  data_out holds a complete word
- ready  input  1  consumer accepts word when valid&ready
- alarm  output  1  sticky repetition-count fault flag

Behaviour:
- Reset values (async, rst=1): state=FILL, data_out=0, valid=0, alarm=0, bit counter=0, shift register=0, run counter=0, last-bit=0.
- Run-counter first-bit flag is set on reset.
- Clock domain: all outputs are registered; no combinational path from inputs to outputs.
- States:
  - FILL: collecting bits.
  - FULL: word held on data_out.
  - FAULT: health test failed.
- FILL, on a cycle with enb=1:
  - Shift left, bit_in enters the LSB, bit counter +1.
  - On the cycle the WIDTH-th bit is sampled, the next edge loads data_out={shreg[WIDTH-2:0],bit_in}, sets valid=1, clears the counter, and moves to FULL.
  - enb=0: hold everything.
- FULL:
  - Sampled bits are discarded for packing but still feed the health test.
  - On valid&ready, valid=0 at the next edge and the state returns to FILL with an empty word.
  - data_out keeps its last value after the handshake.
- Repetition test (all states except FAULT, only when enb=1):
  - First sampled bit after reset/clr sets run=1.
  - bit_in==last-bit increments run (saturating); a differing bit sets run=1.
  - When run would reach REP_LIMIT, the next edge sets alarm=1, forces valid=0, discards the partial word, and moves to FAULT.
- FAULT:
  - No sampling; alarm and valid held.
  - Exits only on clr, to FILL with run state re-armed.
- Priority: rst > clr > alarm trigger > handshake/pack. Examples:
  - clr together with valid&ready: word dropped, valid=0.
  - Alarm trigger on the same cycle as the WIDTH-th bit: FAULT, valid stays 0.
- clr with enb=1: that cycle's bit_in is ignored.

Optional Feature:
- Macro: TRNG_VN_DEBIAS_EN.
- Defined:
  - Von Neumann corrector between sampling and packing.
  - Sampled raw bits are taken in pairs: 01→0, 10→1, 00/11→no output.
  - Only corrector outputs shift in and count toward WIDTH.
  - The pair phase resets on rst/clr and on entry to FILL.
  - The repetition test still runs on raw bits.
- Not defined: every sampled raw bit is packed directly.

Decomposition:
- Package trng_collect_pkg:
  - State encoding constants FILL/FULL/FAULT.
  - Default WIDTH and REP_LIMIT constants.
  - Counter-width helper constants sized from WIDTH and REP_LIMIT.
- Sub-module rep_count_test:
  - Inputs: clk, rst, clr, enb, bit_in, limit.
  - Output: single-cycle fail pulse.
  - Lets the same health test be reused on other entropy sources.

Test Plan:
- Reset, then enb=1 with bit_in alternating 1,0,… for 32 cycles → valid rises the edge after the 32nd sample, data_out=0xAAAAAAAA, alarm=0.
- Same, ready held 0 for 10 cycles then pulsed 1 → data_out and valid stable throughout the stall; valid=0 one edge after the handshake; next word collected from fresh samples.
- 16 consecutive sampled 1s → alarm=1 and valid=0 the edge after the 16th bit; further bits ignored; clr → alarm=0, state FILL, counter 0.
- enb toggled 1/0 every cycle with alternating bits → word completes after 32 enabled samples (64 cycles); value 0xAAAAAAAA.
- clr asserted on the same cycle as valid&ready → valid=0, word dropped, no alarm.
- With TRNG_VN_DEBIAS_EN: raw pairs 01,10,00,11 repeated → only 0,1 packed per 8 raw bits; full word after 128 enabled samples, data_out=0x55555555.
